// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
// Shared types and constants for the fetch PC sequencer slice.
//   state_t    : sequencer FSM states (BOOT, RUN, MISS), 2-bit encoding
//   next_sel_t : selector for the next-PC mux (hold / sequential / target)
//   ADDR_W     : fetch address width
//   STEP_DEFAULT    : default sequential PC increment
//   ADDR_ALIGN_MASK : clears the byte-offset bits of a word address
// ---------------------------------------------------------------------------
package pc_seq_pkg;

    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] STEP_DEFAULT    = 32'd4;
    localparam logic [ADDR_W-1:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_SEQ  = 2'd1,
        SEL_TGT  = 2'd2
    } next_sel_t;

endpackage

// File: rtl/pc_next_calc.sv
// ---------------------------------------------------------------------------
// pc_next_calc
// Combinational next-PC select.
// Ports:
//   pc      (in)  : current fetch address
//   target  (in)  : redirect address; byte-offset bits are dropped here
//   sel     (in)  : SEL_HOLD keeps pc, SEL_SEQ adds STEP (wraps mod 2^32),
//                   SEL_TGT loads the word-aligned target
//   pc_next (out) : value the PC register takes at the next edge
// ---------------------------------------------------------------------------
module pc_next_calc
    import pc_seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] STEP = STEP_DEFAULT
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] target,
    input  next_sel_t         sel,
    output logic [ADDR_W-1:0] pc_next
);

    // Three-way mux; the sequential add relies on natural 32-bit wrap.
    always_comb begin
        pc_next = pc;
        case (sel)
            SEL_SEQ: pc_next = pc + STEP;
            SEL_TGT: pc_next = target & ADDR_ALIGN_MASK;
            default: pc_next = pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Instruction-fetch PC sequencer with I-cache miss handling and branch
// redirects. Optional MIPS branch delay slot compiled in by defining the
// macro PC_SEQUENCER_DELAY_SLOT_EN.
// Parameters:
//   RESET_VEC : PC value loaded by reset
//   STEP      : sequential PC increment
// Ports:
//   clk         (in)  : clock, rising edge
//   rstn        (in)  : synchronous reset, active high (1 = reset)
//   hit         (in)  : I-cache hit for the current pc
//   stall       (in)  : downstream hold, pc does not advance
//   br_valid    (in)  : one-cycle redirect request
//   br_target   (in)  : redirect address, bits [1:0] ignored
//   refill_ack  (in)  : refill completion pulse, only honoured in MISS
//   pc          (out) : current fetch address (registered)
//   pc_en       (out) : high in the cycle whose edge loads a new pc
//   fetch_valid (out) : instruction at pc delivered this cycle
//   refill_req  (out) : level refill request while in MISS
//   refill_addr (out) : word-aligned miss address, zero when idle
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] STEP      = STEP_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              hit,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              refill_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_en,
    output logic              fetch_valid,
    output logic              refill_req,
    output logic [ADDR_W-1:0] refill_addr
);

    state_t            state, state_nxt;
    next_sel_t         sel;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] tgt_sel;
    logic              pend_valid, pend_valid_nxt;
    logic [ADDR_W-1:0] pend_target, pend_target_nxt;
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
    // Set once the delay-slot instruction has been fetched past, so the
    // next advance goes to the pending target.
    logic              pend_slot, pend_slot_nxt;
`endif

    pc_next_calc #(
        .STEP    (STEP)
    ) u_next (
        .pc      (pc),
        .target  (tgt_sel),
        .sel     (sel),
        .pc_next (pc_nxt)
    );

    // State, PC and pending-redirect registers; reset wins over everything,
    // which also drops any refill in flight.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state       <= BOOT;
            pc          <= RESET_VEC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
            pend_slot   <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_target <= pend_target_nxt;
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
            pend_slot   <= pend_slot_nxt;
`endif
        end
    end

    // Next-state and next-PC selection. A redirect that cannot be taken
    // right away is parked in pend_*; a newer br_valid always overwrites it.
    always_comb begin
        state_nxt       = state;
        sel             = SEL_HOLD;
        tgt_sel         = pend_target;
        pend_valid_nxt  = pend_valid;
        pend_target_nxt = pend_target;
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
        pend_slot_nxt   = pend_slot;
`endif
        case (state)
            BOOT: begin
                state_nxt = RUN;
                if (br_valid) begin
                    pend_valid_nxt  = 1'b1;
                    pend_target_nxt = br_target;
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
                    pend_slot_nxt   = 1'b0;
`endif
                end
            end
            RUN: begin
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
                // The advance that coincides with br_valid is the delay
                // slot itself; the following advance takes the target.
                if (hit && !stall) begin
                    sel = SEL_SEQ;
                    if (br_valid) begin
                        pend_valid_nxt  = 1'b1;
                        pend_target_nxt = br_target;
                        pend_slot_nxt   = 1'b1;
                    end else if (pend_valid && pend_slot) begin
                        sel            = SEL_TGT;
                        pend_valid_nxt = 1'b0;
                        pend_slot_nxt  = 1'b0;
                    end else if (pend_valid) begin
                        pend_slot_nxt = 1'b1;
                    end
                end else begin
                    if (br_valid) begin
                        pend_valid_nxt  = 1'b1;
                        pend_target_nxt = br_target;
                        pend_slot_nxt   = 1'b0;
                    end
                    if (!hit) begin
                        state_nxt = MISS;
                    end
                end
`else
                // Redirects take priority over both stall and a miss.
                if (br_valid) begin
                    sel            = SEL_TGT;
                    tgt_sel        = br_target;
                    pend_valid_nxt = 1'b0;
                end else if (pend_valid) begin
                    sel            = SEL_TGT;
                    pend_valid_nxt = 1'b0;
                end else if (!hit) begin
                    state_nxt = MISS;
                end else if (!stall) begin
                    sel = SEL_SEQ;
                end
`endif
            end
            MISS: begin
                if (br_valid) begin
                    pend_valid_nxt  = 1'b1;
                    pend_target_nxt = br_target;
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
                    pend_slot_nxt   = 1'b0;
`endif
                end
                if (refill_ack) begin
                    state_nxt = RUN;
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
                    // The parked redirect waits for its delay slot in RUN.
`else
                    // Leave MISS straight onto the parked (or same-cycle)
                    // redirect target.
                    if (br_valid) begin
                        sel            = SEL_TGT;
                        tgt_sel        = br_target;
                        pend_valid_nxt = 1'b0;
                    end else if (pend_valid) begin
                        sel            = SEL_TGT;
                        pend_valid_nxt = 1'b0;
                    end
`endif
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // Status outputs decoded from the registered state; the refill address
    // is frozen because pc only changes on the edge that leaves MISS.
    always_comb begin
        pc_en       = (sel != SEL_HOLD);
        fetch_valid = (state == RUN) && hit;
        refill_req  = (state == MISS);
        refill_addr = (state == MISS) ? (pc & ADDR_ALIGN_MASK) : '0;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed self-checking bench for pc_sequencer (RESET_VEC=0, STEP=4).
// Expectations follow the build's PC_SEQUENCER_DELAY_SLOT_EN setting.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        hit;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        refill_ack;
    logic [31:0] pc;
    logic        pc_en;
    logic        fetch_valid;
    logic        refill_req;
    logic [31:0] refill_addr;

    int num_compared   = 0;
    int num_mismatched = 0;

    pc_sequencer #(
        .RESET_VEC (32'h0000_0000),
        .STEP      (32'd4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .hit         (hit),
        .stall       (stall),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .refill_ack  (refill_ack),
        .pc          (pc),
        .pc_en       (pc_en),
        .fetch_valid (fetch_valid),
        .refill_req  (refill_req),
        .refill_addr (refill_addr)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Advance past the next rising edge so registered outputs are settled.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drive all inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic r, input logic h, input logic s,
                                 input logic bv, input logic [31:0] bt,
                                 input logic ack);
        rstn       = r;
        hit        = h;
        stall      = s;
        br_valid   = bv;
        br_target  = bt;
        refill_ack = ack;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_compared++;
        assert (observed === expected) else begin
            num_mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence.
    initial begin
        applyStimulus(1, 0, 0, 0, 32'h0, 0);
        tick();
        tick();
        checkOutput("reset_pc", pc, 32'h0);
        checkOutput("reset_pc_en", {31'b0, pc_en}, 32'h0);
        checkOutput("reset_fetch_valid", {31'b0, fetch_valid}, 32'h0);
        checkOutput("reset_refill_req", {31'b0, refill_req}, 32'h0);
        checkOutput("reset_refill_addr", refill_addr, 32'h0);

        // BOOT cycle: no fetch, no advance
        applyStimulus(0, 1, 0, 0, 32'h0, 0);
        checkOutput("boot_fetch_valid", {31'b0, fetch_valid}, 32'h0);
        checkOutput("boot_pc_en", {31'b0, pc_en}, 32'h0);
        checkOutput("boot_pc", pc, 32'h0);

        // sequential run 0,4,8,12
        tick();
        checkOutput("run0_pc", pc, 32'h0);
        checkOutput("run0_fetch_valid", {31'b0, fetch_valid}, 32'h1);
        checkOutput("run0_pc_en", {31'b0, pc_en}, 32'h1);
        tick();
        checkOutput("run1_pc", pc, 32'h4);
        checkOutput("run1_pc_en", {31'b0, pc_en}, 32'h1);
        tick();
        checkOutput("run2_pc", pc, 32'h8);
        tick();
        checkOutput("run3_pc", pc, 32'hC);
        tick();
        checkOutput("run4_pc", pc, 32'h10);

        // miss at 0x10 with refill_ack on the third MISS cycle
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        checkOutput("miss_fetch_valid", {31'b0, fetch_valid}, 32'h0);
        checkOutput("miss_pc_en", {31'b0, pc_en}, 32'h0);
        tick();
        checkOutput("miss1_refill_req", {31'b0, refill_req}, 32'h1);
        checkOutput("miss1_refill_addr", refill_addr, 32'h10);
        checkOutput("miss1_pc_en", {31'b0, pc_en}, 32'h0);
        tick();
        checkOutput("miss2_refill_req", {31'b0, refill_req}, 32'h1);
        checkOutput("miss2_pc", pc, 32'h10);
        tick();
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        checkOutput("miss3_refill_req", {31'b0, refill_req}, 32'h1);
        checkOutput("miss3_refill_addr", refill_addr, 32'h10);
        tick();
        applyStimulus(0, 1, 0, 0, 32'h0, 0);
        checkOutput("resume_refill_req", {31'b0, refill_req}, 32'h0);
        checkOutput("resume_pc", pc, 32'h10);
        checkOutput("resume_fetch_valid", {31'b0, fetch_valid}, 32'h1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("walk_pc", pc, 32'h20);

        // stall holds pc with the instruction still delivered
        applyStimulus(0, 1, 1, 0, 32'h0, 0);
        checkOutput("stall_pc_en", {31'b0, pc_en}, 32'h0);
        checkOutput("stall_fetch_valid", {31'b0, fetch_valid}, 32'h1);
        tick();
        checkOutput("stall_pc", pc, 32'h20);

        // redirect while stalled, target 0x103 -> 0x100
        applyStimulus(0, 1, 1, 1, 32'h103, 0);
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
        checkOutput("br_stall_pc_en", {31'b0, pc_en}, 32'h0);
        tick();
        applyStimulus(0, 1, 0, 0, 32'h0, 0);
        checkOutput("br_stall_hold_pc", pc, 32'h20);
        tick();
        checkOutput("br_stall_slot_pc", pc, 32'h24);
        tick();
`else
        checkOutput("br_stall_pc_en", {31'b0, pc_en}, 32'h1);
        tick();
        applyStimulus(0, 1, 0, 0, 32'h0, 0);
`endif
        checkOutput("br_stall_target_pc", pc, 32'h100);

        // redirect to 0x40, then branch at 0x40 to 0x200
        applyStimulus(0, 1, 0, 1, 32'h40, 0);
        tick();
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
        applyStimulus(0, 1, 0, 0, 32'h0, 0);
        checkOutput("br40_slot_pc", pc, 32'h104);
        tick();
`endif
        checkOutput("br40_pc", pc, 32'h40);
        applyStimulus(0, 1, 0, 1, 32'h200, 0);
        tick();
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
        applyStimulus(0, 1, 0, 0, 32'h0, 0);
        checkOutput("br200_slot_pc", pc, 32'h44);
        tick();
`endif
        checkOutput("br200_pc", pc, 32'h200);

        // wrap from 0xFFFF_FFFC to 0
        applyStimulus(0, 1, 0, 1, 32'hFFFF_FFFC, 0);
        tick();
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
        applyStimulus(0, 1, 0, 0, 32'h0, 0);
        checkOutput("brtop_slot_pc", pc, 32'h204);
        tick();
`endif
        applyStimulus(0, 1, 0, 0, 32'h0, 0);
        checkOutput("top_pc", pc, 32'hFFFF_FFFC);
        checkOutput("top_pc_en", {31'b0, pc_en}, 32'h1);
        tick();
        checkOutput("wrap_pc", pc, 32'h0);

        // redirects during MISS: latest target wins, applied on refill_ack
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 32'h2F0, 0);
        checkOutput("missbr_pc_en", {31'b0, pc_en}, 32'h0);
        checkOutput("missbr_refill_req", {31'b0, refill_req}, 32'h1);
        tick();
        applyStimulus(0, 0, 0, 1, 32'h300, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
        checkOutput("missack_pc_en", {31'b0, pc_en}, 32'h0);
        tick();
        applyStimulus(0, 1, 0, 0, 32'h0, 0);
        checkOutput("missack_refill_req", {31'b0, refill_req}, 32'h0);
        checkOutput("missack_pc", pc, 32'h0);
        tick();
        checkOutput("missack_slot_pc", pc, 32'h4);
        tick();
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
`else
        checkOutput("missack_pc_en", {31'b0, pc_en}, 32'h1);
        tick();
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        checkOutput("missack_refill_req", {31'b0, refill_req}, 32'h0);
`endif
        checkOutput("missack_target_pc", pc, 32'h300);

        // reset in the middle of a second refill
        tick();
        checkOutput("miss2nd_refill_req", {31'b0, refill_req}, 32'h1);
        checkOutput("miss2nd_refill_addr", refill_addr, 32'h300);
        applyStimulus(1, 0, 0, 0, 32'h0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        checkOutput("midreset_refill_req", {31'b0, refill_req}, 32'h0);
        checkOutput("midreset_refill_addr", refill_addr, 32'h0);
        checkOutput("midreset_pc", pc, 32'h0);
        checkOutput("midreset_pc_en", {31'b0, pc_en}, 32'h0);
        tick();
        checkOutput("lateack_refill_req", {31'b0, refill_req}, 32'h0);
        checkOutput("lateack_pc", pc, 32'h0);
        checkOutput("lateack_fetch_valid", {31'b0, fetch_valid}, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        tick();
        checkOutput("remiss_refill_req", {31'b0, refill_req}, 32'h1);
        checkOutput("remiss_pc", pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, is the PC value loaded by reset.
REQ-002 Parameter STEP, default 32'd4, is the sequential PC increment.
REQ-003 Port clk  input  1  is the single clock; all state updates on rising edge.
REQ-004 Port rstn  input  1  is the reset; it SHALL be synchronous and active-high (1 = reset).
REQ-005 Port hit  input  1  is the I-cache hit for the current pc.
REQ-006 Port stall  input  1  is the downstream hold; the PC does not advance.
REQ-007 Port br_valid  input  1  is a one-cycle redirect request.
REQ-008 Port br_target  input  32  is the redirect address; bits [1:0] are ignored and forced to 0.
REQ-009 Port refill_ack  input  1  is the memory refill completion pulse.
REQ-010 Port pc  output  32  is the current fetch address (registered).
REQ-011 Port pc_en  output  1  is high for the cycle in which pc is loaded with a new value.
REQ-012 Port fetch_valid  output  1  is high when the instruction at pc is delivered this cycle (RUN && hit).
REQ-013 Port refill_req  output  1  is the level refill request, held until refill_ack.
REQ-014 Port refill_addr  output  32  is the miss address {pc[31:2],2'b00}, stable while refill_req is high.

Function
REQ-015 FSM states: BOOT, RUN, MISS; the encoding is 2 bits.
REQ-016 BOOT lasts exactly one cycle after reset release, with fetch_valid=0, and then goes to RUN.
REQ-017 In RUN with hit=1, stall=0 and no redirect due, pc SHALL become pc+STEP mod 2^32 (32'hFFFF_FFFC -> 0), with pc_en=1.
REQ-018 In RUN with hit=1 and stall=1, pc, pc_en=0 and fetch_valid=1 SHALL all hold.
REQ-019 In RUN with hit=0, the FSM goes to MISS next cycle, refill_req rises the next cycle, fetch_valid=0 and pc holds.
REQ-020 In MISS, refill_req SHALL stay high until refill_ack; on refill_ack it falls in the following cycle, the FSM returns to RUN and pc is re-looked-up.
REQ-021 A refill SHALL never be aborted; refill_ack outside MISS is ignored.
REQ-022 br_valid in RUN overrides stall and hit; without the delay slot, pc=br_target next cycle with pc_en=1.
REQ-023 br_valid in MISS is stored as pending; on refill_ack, pc=target in the same update and pc_en=1.
REQ-024 A second br_valid while a redirect is pending SHALL overwrite the stored target (the latest wins).
REQ-025 pc_en SHALL never be asserted in BOOT or MISS, except per REQ-023.

Reset
REQ-026 With rstn=1 at a clock edge: pc=RESET_VEC, state=BOOT, pc_en=0, fetch_valid=0, refill_req=0, refill_addr=0, and the pending redirect is cleared.
REQ-027 Reset mid-refill SHALL drop refill_req next cycle; a later refill_ack is ignored.

Configuration
REQ-028 Macro PC_SEQUENCER_DELAY_SLOT_EN compiles in the MIPS branch delay slot.
REQ-029 With the macro defined, br_valid becomes pending; the next advance goes to pc+STEP (the delay slot), and the advance after that goes to the target.
REQ-030 Without the macro, the redirect applies per REQ-022/023 and the delay-slot logic is absent.

Structure
REQ-031 Shared package pc_seq_pkg SHALL hold the state typedef (BOOT/RUN/MISS), the STEP default and the address width constant 32.
REQ-032 Sub-module pc_next_calc (combinational next-PC select: sequential/target/hold) is natural; the FSM and registers stay in pc_sequencer.

Verification
REQ-033 Reset with RESET_VEC=0, then hit=1 for 4 cycles -> pc 0 (BOOT), 0, 4, 8, 12; pc_en=1 on each advance.
REQ-034 At pc=0x10, hit=0, refill_ack after 3 cycles -> refill_req high 3 cycles, refill_addr=0x10, pc holds 0x10, then fetch resumes at 0x10.
REQ-035 At pc=0x20 in RUN, stall=1 and br_valid=1 with br_target=0x103 -> pc=0x100 next cycle (no delay slot).
REQ-036 With the macro defined, at pc=0x40, br_valid with target 0x200 -> pc 0x44, then 0x200.
REQ-037 At pc=0xFFFF_FFFC, hit=1 -> pc=0 next cycle.
REQ-038 br_valid (0x300) during MISS, then refill_ack -> pc=0x300 in the cycle after the ack; rstn pulsed during a second MISS -> refill_req=0 next cycle.
